// File: rtl/disp_pkg.sv
// Shared definitions for the display mode controller: mode encoding and
// packed-nibble digit layout ([3:0] = digit 1 ... [31:28] = digit 8).
package disp_pkg;

    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned NUM_DIGITS = 8;

    typedef logic [NUM_DIGITS*DIGIT_W-1:0] digits_t;
    typedef logic [NUM_DIGITS-1:0]         digit_vec_t;

    typedef enum logic [1:0] {
        MODE_TIME  = 2'd0,
        MODE_ALARM = 2'd1,
        MODE_TIMER = 2'd2,
        MODE_RING  = 2'd3
    } mode_e;

endpackage

// File: rtl/disp_mode_ctrl_if.sv
// Control and digit buses between the display mode controller and its
// surrounding logic (master = stimulus side, slave = controller side).
interface disp_mode_ctrl_if;
    import disp_pkg::*;

    logic       mode_btn;
    logic       edit_active;
    logic [1:0] edit_field;
    logic       alarm_ring;
    digits_t    time_digits;
    digits_t    alarm_digits;
    digits_t    timer_digits;
    digits_t    digits;
    digit_vec_t point;
    digit_vec_t digit_mask;
    logic [1:0] mode;
    logic       ring_ack;

    modport master (
        output mode_btn, edit_active, edit_field, alarm_ring,
               time_digits, alarm_digits, timer_digits,
        input  digits, point, digit_mask, mode, ring_ack
    );

    modport slave (
        input  mode_btn, edit_active, edit_field, alarm_ring,
               time_digits, alarm_digits, timer_digits,
        output digits, point, digit_mask, mode, ring_ack
    );

endinterface

// File: rtl/disp_blink_timer.sv
// Blink half-period timer: counts tick_ms pulses and toggles the phase
// every BLINK_MS ticks; restart forces count 0 and phase ON.
module disp_blink_timer #(
    parameter int unsigned BLINK_MS = 500
) (
    input  logic clk,
    input  logic reset_n,
    input  logic tick_ms,
    input  logic restart,
    output logic phase_next
);

    localparam int unsigned CW = (BLINK_MS > 1) ? $clog2(BLINK_MS) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          phase_q;

    always_comb begin
        cnt_d      = cnt_q;
        phase_next = phase_q;
        if (restart) begin
            cnt_d      = '0;
            phase_next = 1'b1;
        end else if (tick_ms) begin
            if (cnt_q == CW'(BLINK_MS - 1)) begin
                cnt_d      = '0;
                phase_next = ~phase_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            phase_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_next;
        end
    end

endmodule

// File: rtl/disp_mode_ctrl.sv
// Display mode scheduler: source select, edit blink, ring flash, inactivity
// timeout. Optional macro DISP_SECONDS_DP_EN adds the TIME-mode colon points.
module disp_mode_ctrl
    import disp_pkg::*;
#(
    parameter int unsigned BLINK_MS   = 500,
    parameter int unsigned TIMEOUT_MS = 10000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic tick_ms,
    disp_mode_ctrl_if.slave bus
);

    localparam int unsigned TW = (TIMEOUT_MS > 1) ? $clog2(TIMEOUT_MS) : 1;

    mode_e      state_q, state_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic       in_setting, timeout, restart, phase_d;
    logic       edit_active_q;
    logic [1:0] edit_field_q;
    digits_t    digits_q, digits_d;
    digit_vec_t point_q, point_d, mask_q, mask_d;
    logic       ack_q, ack_d;

    disp_blink_timer #(.BLINK_MS(BLINK_MS)) u_blink (
        .clk        (clk),
        .reset_n    (reset_n),
        .tick_ms    (tick_ms),
        .restart    (restart),
        .phase_next (phase_d)
    );

    always_comb begin
        in_setting = (state_q == MODE_ALARM) || (state_q == MODE_TIMER);
        timeout    = in_setting && tick_ms && !bus.edit_active &&
                     (to_cnt_q == TW'(TIMEOUT_MS - 1));

        state_d = state_q;
        if (bus.alarm_ring) begin
            state_d = MODE_RING;
        end else begin
            case (state_q)
                MODE_TIME:  if (bus.mode_btn) state_d = MODE_ALARM;
                MODE_ALARM: if (bus.mode_btn) state_d = MODE_TIMER;
                            else if (timeout) state_d = MODE_TIME;
                MODE_TIMER: if (bus.mode_btn || timeout) state_d = MODE_TIME;
                default:    state_d = MODE_TIME;
            endcase
        end

        restart = (bus.edit_active && !edit_active_q) ||
                  (bus.edit_field != edit_field_q) ||
                  (state_d != state_q);

        to_cnt_d = to_cnt_q;
        if (!in_setting || bus.mode_btn || bus.edit_active || (state_d != state_q))
            to_cnt_d = '0;
        else if (tick_ms)
            to_cnt_d = to_cnt_q + TW'(1);

        ack_d = (state_q == MODE_RING) && bus.mode_btn;

        case (state_d)
            MODE_ALARM: digits_d = bus.alarm_digits;
            MODE_TIMER: digits_d = bus.timer_digits;
            default:    digits_d = bus.time_digits;
        endcase

        // Masks and points follow the next state/phase so they stay aligned with mode.
        mask_d  = '1;
        point_d = '0;
        if (state_d == MODE_RING) begin
            mask_d  = {NUM_DIGITS{phase_d}};
            point_d = {NUM_DIGITS{phase_d}};
        end else begin
            if (bus.edit_active && !phase_d) begin
                mask_d[{bus.edit_field, 1'b0}] = 1'b0;
                mask_d[{bus.edit_field, 1'b1}] = 1'b0;
            end
`ifdef DISP_SECONDS_DP_EN
            if (state_d == MODE_TIME) begin
                point_d[2] = phase_d;
                point_d[4] = phase_d;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= MODE_TIME;
            to_cnt_q      <= '0;
            edit_active_q <= 1'b0;
            edit_field_q  <= '0;
            digits_q      <= '0;
            point_q       <= '0;
            mask_q        <= '1;
            ack_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            to_cnt_q      <= to_cnt_d;
            edit_active_q <= bus.edit_active;
            edit_field_q  <= bus.edit_field;
            digits_q      <= digits_d;
            point_q       <= point_d;
            mask_q        <= mask_d;
            ack_q         <= ack_d;
        end
    end

    assign bus.mode       = state_q;
    assign bus.digits     = digits_q;
    assign bus.point      = point_q;
    assign bus.digit_mask = mask_q;
    assign bus.ring_ack   = ack_q;

endmodule

// File: tb/tb_disp_mode_ctrl.sv
// Directed testbench for disp_mode_ctrl with BLINK_MS = 4, TIMEOUT_MS = 10.
module tb_disp_mode_ctrl;

    logic clk;
    logic reset_n;
    logic tick_ms;
    int   vectors;
    int   miscompares;

    disp_mode_ctrl_if bus ();

    disp_mode_ctrl #(.BLINK_MS(4), .TIMEOUT_MS(10)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .tick_ms (tick_ms),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        tick_ms = 1'b1;
        cyc();
        tick_ms = 1'b0;
    endtask

    task automatic press();
        bus.mode_btn = 1'b1;
        cyc();
        bus.mode_btn = 1'b0;
    endtask

    task automatic test_reset();
        reset_n          = 1'b0;
        tick_ms          = 1'b0;
        bus.mode_btn     = 1'b0;
        bus.edit_active  = 1'b0;
        bus.edit_field   = 2'd0;
        bus.alarm_ring   = 1'b0;
        bus.time_digits  = 32'hA1B2C3D4;
        bus.alarm_digits = 32'h0;
        bus.timer_digits = 32'h0;
        cyc();
        cyc();
        vectors++;
        if (bus.mode !== 2'd0 || bus.digit_mask !== 8'hFF || bus.point !== 8'h00 ||
            bus.digits !== 32'h0 || bus.ring_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: mode=%0d mask=%h point=%h digits=%h ack=%b, want 0 FF 00 00000000 0",
                     bus.mode, bus.digit_mask, bus.point, bus.digits, bus.ring_ack);
        end
        reset_n = 1'b1;
        cyc();
        vectors++;
        if (bus.mode !== 2'd0 || bus.digits !== 32'hA1B2C3D4 || bus.digit_mask !== 8'hFF) begin
            miscompares++;
            $display("FAIL idle_time: mode=%0d digits=%h mask=%h, want 0 A1B2C3D4 FF",
                     bus.mode, bus.digits, bus.digit_mask);
        end
        bus.time_digits = 32'h87654321;
        cyc();
        vectors++;
        if (bus.digits !== 32'h87654321) begin
            miscompares++;
            $display("FAIL time_follow: digits=%h want 87654321", bus.digits);
        end
    endtask

    task automatic test_mode_seq();
        logic [1:0]  exp_mode [3] = '{2'd1, 2'd2, 2'd0};
        logic [31:0] exp_dig  [3] = '{32'h12345678, 32'hDEADBEEF, 32'h87654321};
        bus.alarm_digits = 32'h12345678;
        bus.timer_digits = 32'hDEADBEEF;
        for (int i = 0; i < 3; i++) begin
            press();
            vectors++;
            if (bus.mode !== exp_mode[i] || bus.digits !== exp_dig[i] || bus.ring_ack !== 1'b0) begin
                miscompares++;
                $display("FAIL mode_seq[%0d]: mode=%0d digits=%h ack=%b, want %0d %h 0",
                         i, bus.mode, bus.digits, bus.ring_ack, exp_mode[i], exp_dig[i]);
            end
            if (i == 0) begin
                vectors++;
                if (bus.point !== 8'h00 || bus.digit_mask !== 8'hFF) begin
                    miscompares++;
                    $display("FAIL alarm_outputs: point=%h mask=%h, want 00 FF", bus.point, bus.digit_mask);
                end
            end
            repeat (4) cyc();
        end
    endtask

    task automatic test_timeout();
        press();
        for (int k = 1; k <= 10; k++) begin
            tick();
            vectors++;
            if (bus.mode !== ((k == 10) ? 2'd0 : 2'd1)) begin
                miscompares++;
                $display("FAIL timeout_tick%0d: mode=%0d want %0d", k, bus.mode, (k == 10) ? 0 : 1);
            end
            cyc();
        end
        press();
        repeat (9) begin
            tick();
            cyc();
        end
        vectors++;
        if (bus.mode !== 2'd1) begin
            miscompares++;
            $display("FAIL timeout_pre: mode=%0d want 1", bus.mode);
        end
        tick_ms      = 1'b1;
        bus.mode_btn = 1'b1;
        cyc();
        tick_ms      = 1'b0;
        bus.mode_btn = 1'b0;
        vectors++;
        if (bus.mode !== 2'd2) begin
            miscompares++;
            $display("FAIL timeout_btn_wins: mode=%0d want 2", bus.mode);
        end
        repeat (3) cyc();
        vectors++;
        if (bus.mode !== 2'd2) begin
            miscompares++;
            $display("FAIL timeout_hold: mode=%0d want 2", bus.mode);
        end
        press();
    endtask

    task automatic test_blink();
        logic [7:0] exp;
        bus.edit_active = 1'b1;
        bus.edit_field  = 2'd2;
        cyc();
        vectors++;
        if (bus.digit_mask !== 8'hFF) begin
            miscompares++;
            $display("FAIL blink_start: mask=%h want FF", bus.digit_mask);
        end
        for (int k = 1; k <= 12; k++) begin
            tick();
            exp = ((k >= 4 && k <= 7) || k >= 12) ? 8'hCF : 8'hFF;
            vectors++;
            if (bus.digit_mask !== exp) begin
                miscompares++;
                $display("FAIL blink_tick%0d: mask=%h want %h", k, bus.digit_mask, exp);
            end
            cyc();
        end
        bus.edit_field = 2'd0;
        cyc();
        vectors++;
        if (bus.digit_mask !== 8'hFF) begin
            miscompares++;
            $display("FAIL blink_field_restart: mask=%h want FF", bus.digit_mask);
        end
        for (int k = 1; k <= 4; k++) begin
            tick();
            exp = (k == 4) ? 8'hFC : 8'hFF;
            vectors++;
            if (bus.digit_mask !== exp) begin
                miscompares++;
                $display("FAIL blink_f0_tick%0d: mask=%h want %h", k, bus.digit_mask, exp);
            end
        end
        bus.edit_active = 1'b0;
        cyc();
        vectors++;
        if (bus.digit_mask !== 8'hFF) begin
            miscompares++;
            $display("FAIL blink_edit_off: mask=%h want FF", bus.digit_mask);
        end
    endtask

    task automatic test_ring();
        logic [7:0] exp;
        press();
        press();
        bus.alarm_ring = 1'b1;
        bus.mode_btn   = 1'b1;
        cyc();
        bus.mode_btn   = 1'b0;
        vectors++;
        if (bus.mode !== 2'd3 || bus.ring_ack !== 1'b0 || bus.digits !== 32'h87654321 ||
            bus.point !== 8'hFF || bus.digit_mask !== 8'hFF) begin
            miscompares++;
            $display("FAIL ring_enter: mode=%0d ack=%b digits=%h point=%h mask=%h, want 3 0 87654321 FF FF",
                     bus.mode, bus.ring_ack, bus.digits, bus.point, bus.digit_mask);
        end
        cyc();
        vectors++;
        if (bus.ring_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL ring_no_ack: ack=%b want 0", bus.ring_ack);
        end
        press();
        vectors++;
        if (bus.ring_ack !== 1'b1 || bus.mode !== 2'd3) begin
            miscompares++;
            $display("FAIL ring_ack: ack=%b mode=%0d want 1 3", bus.ring_ack, bus.mode);
        end
        cyc();
        vectors++;
        if (bus.ring_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL ring_ack_pulse: ack=%b want 0", bus.ring_ack);
        end
        for (int k = 1; k <= 8; k++) begin
            tick();
            exp = (k >= 4 && k <= 7) ? 8'h00 : 8'hFF;
            vectors++;
            if (bus.point !== exp || bus.digit_mask !== exp) begin
                miscompares++;
                $display("FAIL ring_flash%0d: point=%h mask=%h want %h", k, bus.point, bus.digit_mask, exp);
            end
        end
    endtask

    task automatic test_reset_ring();
        repeat (4) tick();
        vectors++;
        if (bus.digit_mask !== 8'h00) begin
            miscompares++;
            $display("FAIL ring_off_phase: mask=%h want 00", bus.digit_mask);
        end
        reset_n = 1'b0;
        #1;
        vectors++;
        if (bus.mode !== 2'd0 || bus.digit_mask !== 8'hFF || bus.point !== 8'h00 ||
            bus.digits !== 32'h0 || bus.ring_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_ring: mode=%0d mask=%h point=%h digits=%h ack=%b, want 0 FF 00 00000000 0",
                     bus.mode, bus.digit_mask, bus.point, bus.digits, bus.ring_ack);
        end
        cyc();
        reset_n = 1'b1;
        cyc();
        vectors++;
        if (bus.mode !== 2'd3 || bus.digit_mask !== 8'hFF) begin
            miscompares++;
            $display("FAIL ring_reenter: mode=%0d mask=%h want 3 FF", bus.mode, bus.digit_mask);
        end
        bus.alarm_ring = 1'b0;
        cyc();
        vectors++;
        if (bus.mode !== 2'd0 || bus.point !== 8'h00 && bus.point !== 8'h14) begin
            miscompares++;
            $display("FAIL ring_exit: mode=%0d point=%h want 0", bus.mode, bus.point);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_mode_seq();
        test_timeout();
        test_blink();
        test_ring();
        test_reset_ring();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/disp_mode_ctrl.md
Name: disp_mode_ctrl

Overview:
- Scheduler for the 8-digit scanned 7-segment display.
- Selects which digit source (time, alarm setting, countdown timer) drives the scan driver's eight 4-bit digit inputs and its point vector.
- Runs the edit-blink and alarm-ring flash timing, and auto-returns to time display after inactivity.
- The top level ANDs the scan driver's anode vector with digit_mask; this is the only digit-blanking path.

Parameters:
- BLINK_MS, 500, blink half-period in tick_ms pulses.
- TIMEOUT_MS, 10000, inactivity time in ALARM/TIMER before returning to TIME, in tick_ms pulses.

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset, asynchronous, active-low
- tick_ms  in  1  one-cycle pulse every 1 ms
- mode_btn  in  1  debounced one-cycle pulse: advance mode
- edit_active  in  1  level: a field is being edited
- edit_field  in  2  edited digit pair: 0 = digits 1-2, 1 = 3-4, 2 = 5-6, 3 = 7-8
- alarm_ring  in  1  level: alarm is sounding
- time_digits  in  32  packed nibbles; [3:0] = digit 1 ... [31:28] = digit 8
- alarm_digits  in  32  same packing
- timer_digits  in  32  same packing
- digits  out  32  selected nibbles to the scan driver
- point  out  8  decimal points to the scan driver
- digit_mask  out  8  per-digit enable; 1 = lit
- mode  out  2  current state: 0 TIME, 1 ALARM, 2 TIMER, 3 RING
- ring_ack  out  1  one-cycle pulse: mode_btn pressed during RING

Behaviour:
- All outputs registered. One-cycle latency from any input change to outputs.
- Reset values: mode = TIME, digits = 0, point = 0, digit_mask = 8'hFF, ring_ack = 0, blink_cnt = 0, blink phase = ON, timeout_cnt = 0.
- FSM transitions:
  - TIME -> ALARM -> TIMER -> TIME, one step per mode_btn.
  - Any state -> RING when alarm_ring = 1. RING has priority over a simultaneous mode_btn.
  - RING -> TIME when alarm_ring falls.
  - mode_btn in RING: no state change; ring_ack pulses the next cycle.
- Source selection:
  - TIME and RING select time_digits.
  - ALARM selects alarm_digits.
  - TIMER selects timer_digits.
- Blink timer:
  - blink_cnt increments on tick_ms.
  - At BLINK_MS-1 with tick_ms: phase toggles and blink_cnt returns to 0.
  - Restart (blink_cnt = 0, phase = ON) on: rising edge of edit_active, any change of edit_field, any state change.
  - Restart has priority over the toggle in the same cycle.
- digit_mask:
  - RING: all bits = phase.
  - Non-RING, edit_active = 1 and phase OFF: bits 2*edit_field and 2*edit_field+1 are 0, all others 1.
  - Otherwise 8'hFF.
- point:
  - RING: 8'hFF when phase ON, 8'h00 when OFF.
  - Otherwise 8'h00, except as modified by the optional feature.
- Timeout:
  - timeout_cnt counts tick_ms only in ALARM or TIMER.
  - Cleared on mode_btn, while edit_active = 1, and on any state change.
  - At TIMEOUT_MS-1 with tick_ms: next state TIME.
  - A mode_btn in the same cycle wins: the normal advance is taken and the counter clears.
  - Counter width is clog2(TIMEOUT_MS); no wrap is reachable.
- Reset asserted mid-operation, including during RING: immediate return to the reset values. After reset release, RING is re-entered on the next cycle if alarm_ring is still 1.

Optional Feature:
- Macro: DISP_SECONDS_DP_EN.
- Defined: in TIME state, point[2] and point[4] equal the blink phase (1 Hz colon effect with default BLINK_MS), also when not editing.
- Undefined: point is 8'h00 in all non-RING states.

Decomposition:
- Shared package disp_pkg holds:
  - mode encoding constants MODE_TIME, MODE_ALARM, MODE_TIMER, MODE_RING;
  - DIGIT_W = 4 and NUM_DIGITS = 8;
  - the packed-nibble layout.
- One sub-module: disp_blink_timer (tick_ms counter, restart input, phase output). It is reused by the timeout path only through its counter pattern, not instantiated twice.

Test Plan:
- Reset release, no input activity -> mode = 0, digit_mask = FF, point = 00, digits = time_digits one cycle after each change.
- Three mode_btn pulses 5 cycles apart, alarm_digits = 32'h12345678 -> mode sequence 1, 2, 0. digits = 32'h12345678 while mode = 1.
- BLINK_MS = 4, TIMEOUT_MS = 10, enter ALARM, drive 10 tick_ms pulses with no buttons -> mode returns to 0 one cycle after the 10th tick. Repeating with mode_btn on the 10th tick -> mode = 2, no timeout.
- BLINK_MS = 4, edit_active = 1, edit_field = 2 -> digit_mask = FF for 4 ticks, then CF for 4 ticks, repeating. Changing edit_field to 0 while OFF -> mask = FF next cycle, then FC after 4 ticks.
- alarm_ring and mode_btn asserted in the same cycle from TIMER -> mode = 3, no ring_ack. A later mode_btn -> ring_ack = 1 for one cycle. point and digit_mask toggle between FF and 00 every 4 ticks.
- Assert reset_n = 0 mid-RING with alarm_ring = 1 -> outputs immediately at reset values. After release -> mode = 3 on the next cycle.
